// File: rtl/mac_buf_pkg.sv
// rtl/mac_buf_pkg.sv - shared widths and delay helpers for the MAC sum buffer
package mac_buf_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 14;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // A zero request still means "at least one stage"; oversize requests saturate.
  function automatic int clamp_delay(input int x, input int depth);
    if (x == 0) return 1;
    if (x > depth) return depth;
    return x;
  endfunction

endpackage

// File: rtl/mac_delay_stage.sv
// rtl/mac_delay_stage.sv - one {valid, data} stage of the sum delay line
module mac_delay_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             advance_i,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Clearing only kills the valid tag; the data word is left as is.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (advance_i) begin
      valid_d = valid_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/sum_delay_line.sv
// rtl/sum_delay_line.sv - stallable, flushable delay line with runtime tap; SUM_DELAY_OCC_EN adds the occ counter
module sum_delay_line
  import mac_buf_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int RESET_DELAY = DEPTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         stall,
  input  logic                         flush,
  input  logic [clog2(DEPTH+1)-1:0]    delay_sel,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  output logic                         delay_busy,
  output logic [clog2(DEPTH+1)-1:0]    d_active
`ifdef SUM_DELAY_OCC_EN
  ,
  output logic [clog2(DEPTH+1)-1:0]    occ
`endif
);

  localparam int DW = clog2(DEPTH + 1);

  logic             advance;
  logic             accept;
  logic             pipe_empty;
  logic             change;
  logic             clear;
  logic [DW-1:0]    req_delay;
  logic [DW-1:0]    d_active_q, d_active_d;
  logic [DEPTH:0]   v_chain;
  logic [WIDTH-1:0] d_chain [DEPTH+1];

  assign advance    = !stall;
  assign accept     = in_valid & advance & !flush;
  assign in_ready   = advance;
  assign req_delay  = DW'(clamp_delay(int'(delay_sel), DEPTH));
  assign delay_busy = (req_delay != d_active_q);

  assign v_chain[0] = accept;
  assign d_chain[0] = in_data;

  for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
    mac_delay_stage #(.WIDTH(WIDTH)) u_stage (
      .clock     (clock),
      .reset     (reset),
      .advance_i (advance),
      .clear_i   (clear),
      .valid_i   (v_chain[k-1]),
      .data_i    (d_chain[k-1]),
      .valid_o   (v_chain[k]),
      .data_o    (d_chain[k])
    );
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (d_active_q == DW'(k)) begin
        out_valid = v_chain[k];
        out_data  = d_chain[k];
      end
    end
  end

`ifdef SUM_DELAY_OCC_EN
  logic          retire;
  logic [DW-1:0] occ_q, occ_d;

  assign retire = out_valid & advance;

  always_comb begin
    occ_d = occ_q;
    if (flush) occ_d = '0;
    else       occ_d = occ_q + DW'(accept) - DW'(retire);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) occ_q <= '0;
    else       occ_q <= occ_d;
  end

  assign occ        = occ_q;
  assign pipe_empty = (occ_q == '0);
`else
  // Beats past the tap are already retired, so only stages up to it count.
  always_comb begin
    pipe_empty = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      if (DW'(k) <= d_active_q && v_chain[k]) pipe_empty = 1'b0;
    end
  end
`endif

  // Retargeting also wipes every valid bit so beats stranded beyond the old tap never surface.
  assign change     = delay_busy & pipe_empty & !accept;
  assign clear      = flush | change;
  assign d_active_d = change ? req_delay : d_active_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) d_active_q <= DW'(RESET_DELAY);
    else       d_active_q <= d_active_d;
  end

  assign d_active = d_active_q;

endmodule

// File: tb/tb_sum_delay_line.sv
// tb/tb_sum_delay_line.sv - scoreboard bench for sum_delay_line against a queue-based timing model
module tb_sum_delay_line;

  localparam int WIDTH       = 32;
  localparam int DEPTH       = 14;
  localparam int RESET_DELAY = 14;
  localparam int DW          = 4;

  logic             clock;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             stall;
  logic             flush;
  logic [DW-1:0]    delay_sel;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             delay_busy;
  logic [DW-1:0]    d_active;
`ifdef SUM_DELAY_OCC_EN
  logic [DW-1:0]    occ;
`endif

  sum_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_DELAY(RESET_DELAY)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .stall      (stall),
    .flush      (flush),
    .delay_sel  (delay_sel),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .delay_busy (delay_busy),
    .d_active   (d_active)
`ifdef SUM_DELAY_OCC_EN
    ,
    .occ        (occ)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               due;
  } beat_t;

  // Model: each beat remembers the advance-edge count at which it must first be visible.
  beat_t q[$];
  int    adv_cnt   = 0;
  int    d_m       = RESET_DELAY;
  int    pop_cnt   = 0;
  int    seen_pops = 0;
  bit    running   = 0;
  int    n_checks  = 0;
  int    n_fail    = 0;
  int    cur_sel   = 14;

  function automatic int clampd(input int x);
    if (x == 0) return 1;
    if (x > DEPTH) return DEPTH;
    return x;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    bit ev;
    if (!reset && running) begin
      ev = (q.size() > 0) && (q[0].due <= adv_cnt);
      chk("in_ready", longint'(in_ready), longint'(!stall));
      chk("d_active", longint'(d_active), longint'(d_m));
      chk("delay_busy", longint'(delay_busy), longint'(clampd(int'(delay_sel)) != d_m));
`ifdef SUM_DELAY_OCC_EN
      chk("occ", longint'(occ), longint'(q.size()));
`endif
      chk("out_valid", longint'(out_valid), longint'(ev));
      if (ev) begin
        if (out_valid) begin
          chk("out_data", longint'(out_data), longint'(q[0].data));
          chk("latency", longint'(adv_cnt), longint'(q[0].due));
        end
        if (!stall && !flush) begin
          void'(q.pop_front());
          pop_cnt++;
        end
      end
    end
  end

  task automatic cycle(input bit v, input logic [WIDTH-1:0] dat, input bit st, input bit fl, input int sel);
    bit    acc;
    int    in_flight;
    beat_t b;
    in_valid  = v;
    in_data   = dat;
    stall     = st;
    flush     = fl;
    delay_sel = DW'(sel);
    @(posedge clock);
    in_flight = q.size() + ((pop_cnt != seen_pops) ? 1 : 0);
    seen_pops = pop_cnt;
    acc = v && !st && !fl;
    if (!st) adv_cnt++;
    if (fl) q.delete();
    if (clampd(sel) != d_m && in_flight == 0 && !acc) d_m = clampd(sel);
    if (acc) begin
      b.data = dat;
      b.due  = adv_cnt + d_m - 1;
      q.push_back(b);
    end
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, $urandom, 1'b0, 1'b0, cur_sel);
  endtask

  task automatic beat(input logic [WIDTH-1:0] dat);
    cycle(1'b1, dat, 1'b0, 1'b0, cur_sel);
  endtask

  task automatic check_reset_state();
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_d_active", longint'(d_active), longint'(RESET_DELAY));
`ifdef SUM_DELAY_OCC_EN
    chk("rst_occ", longint'(occ), 0);
`endif
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    reset    = 1'b1;
    #1;
    check_reset_state();
    q.delete();
    d_m       = RESET_DELAY;
    seen_pops = pop_cnt;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    stall     = 1'b0;
    flush     = 1'b0;
    delay_sel = DW'(cur_sel);
    repeat (2) @(posedge clock);
    #1;
    check_reset_state();
    reset   = 1'b0;
    running = 1'b1;

    beat(32'h3F800000);
    beat(32'h40000000);
    beat(32'h40400000);
    idle(20);

    beat(32'hA5A5_0001);
    idle(5);
    repeat (4) cycle(1'b1, $urandom, 1'b1, 1'b0, cur_sel);
    idle(20);
    beat(32'hA5A5_0002);
    idle(13);
    repeat (3) cycle(1'b1, $urandom, 1'b1, 1'b0, cur_sel);
    idle(5);

    repeat (5) beat($urandom);
    cycle(1'b1, $urandom, 1'b1, 1'b1, cur_sel);
    idle(20);

    repeat (2) beat($urandom);
    idle(3);
    cur_sel = 5;
    idle(20);
    beat(32'hC0DE_0005);
    idle(10);

    cur_sel = 0;
    idle(10);
    beat(32'h0000_0001);
    idle(3);
    repeat (3) beat($urandom);
    idle(5);
    cur_sel = 15;
    idle(10);
    beat(32'h0000_000F);
    idle(20);

    cur_sel = 3;
    idle(5);
    repeat (7) beat($urandom);
    pulse_reset();
    idle(25);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) cur_sel = $urandom_range(0, 15);
      if (i % 100 == 99) idle(20);
      cycle($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) == 0,
            $urandom_range(0, 49) == 0, cur_sel);
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
